// File: rtl/uart_port.sv
// ============================================================================
// Module   : uart_port
// Brief    : 8N1 UART with a CPU register port (data/status) and an RX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int RX_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       addr,
  input  logic       RE,
  input  logic       WE,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);

  localparam int          c_AW        = $clog2(RX_DEPTH);
  localparam logic [15:0] c_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] c_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  tx_state_t   r_tx_state;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;

  rx_state_t   r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_rx_meta;
  logic        r_rx_sync;
  logic        r_rx_prev;

  logic [7:0]  r_fifo [RX_DEPTH];
  logic [c_AW:0] r_wptr;
  logic [c_AW:0] r_rptr;
  logic        r_overrun;
  logic        r_frame_err;

  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_rx_done;
  logic        w_push;
  logic        w_write;
  logic        w_ovr_set;
  logic        w_ferr_set;
  logic        w_stat_rd;
  logic        w_tx_busy;
  logic [7:0]  w_status;

  // ---------------------------------------------------------------- TX path
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= 16'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
      tx         <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (WE && !addr) begin
            r_tx_shift <= din;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            tx         <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == c_BIT_LAST) begin
            r_tx_cnt   <= 16'd0;
            tx         <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == c_BIT_LAST) begin
            r_tx_cnt <= 16'd0;
            if (r_tx_bit == 3'd7) begin
              tx         <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              tx         <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (r_tx_cnt == c_BIT_LAST) begin
            r_tx_cnt   <= 16'd0;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_cnt   <= 16'd0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Mid-start resample rejects short low glitches.
          if (r_rx_cnt == c_HALF_LAST) begin
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= 3'd0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == c_BIT_LAST) begin
            r_rx_cnt   <= 16'd0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == c_BIT_LAST) begin
            r_rx_cnt   <= 16'd0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------- FIFO and status
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                      (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign w_pop      = RE && !addr && !w_empty;
  assign w_stat_rd  = RE && addr;
  assign w_rx_done  = (r_rx_state == RX_STOP) && (r_rx_cnt == c_BIT_LAST);
  assign w_push     = w_rx_done && r_rx_sync;
  assign w_ferr_set = w_rx_done && !r_rx_sync;
  // A pop in the same cycle frees the slot the push lands in.
  assign w_write    = w_push && (!w_full || w_pop);
  assign w_ovr_set  = w_push && w_full && !w_pop;
  assign w_tx_busy  = (r_tx_state != TX_IDLE);
  assign w_status   = {4'b0000, r_frame_err, r_overrun, w_tx_busy, !w_empty};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_write) r_wptr <= r_wptr + 1'b1;
      r_overrun   <= w_ovr_set  | (r_overrun   & ~w_stat_rd);
      r_frame_err <= w_ferr_set | (r_frame_err & ~w_stat_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_fifo[r_wptr[c_AW-1:0]] <= r_rx_shift;
  end

  always_comb begin
    dout = 8'h00;
    if (addr) begin
      dout = w_status;
    end else if (!w_empty) begin
      dout = r_fifo[r_rptr[c_AW-1:0]];
    end
  end

  assign irq = !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_port.sv
// ============================================================================
// Module   : tb_uart_port
// Brief    : Directed self-checking bench for uart_port (CLKS_PER_BIT=16).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_port;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       addr;
  logic       RE;
  logic       WE;
  logic [7:0] din;
  logic [7:0] dout;
  logic       rx;
  logic       tx;
  logic       irq;

  int n_checks = 0;
  int n_errors = 0;

  uart_port #(.CLKS_PER_BIT(CPB), .RX_DEPTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .RE   (RE),
    .WE   (WE),
    .din  (din),
    .dout (dout),
    .rx   (rx),
    .tx   (tx),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop;
    repeat (CPB) tick();
    rx = 1'b1;
  endtask

  task automatic status_is(input string tag, input logic [7:0] exp);
    addr = 1'b1;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic read_data(input string tag, input logic [7:0] exp);
    addr = 1'b0;
    #1;
    chk(tag, dout, exp);
    RE = 1'b1;
    tick();
    RE = 1'b0;
  endtask

  task automatic read_status_clear();
    addr = 1'b1;
    RE   = 1'b1;
    tick();
    RE   = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_bit;
    logic [7:0] tx_byte;
    logic [7:0] coll [4];
    coll[0] = 8'h22; coll[1] = 8'h33; coll[2] = 8'h44; coll[3] = 8'h99;

    reset = 1'b0; addr = 1'b0; RE = 1'b0; WE = 1'b0; din = 8'h00; rx = 1'b1;
    repeat (3) tick();
    chk("rst_tx", {7'b0, tx}, 8'h01);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    reset = 1'b1;
    tick();
    status_is("rst_status", 8'h00);
    addr = 1'b0; #1;
    chk("rst_data", dout, 8'h00);

    // TX 0x55, with an ignored write of 0xFF mid-frame
    tx_byte = 8'h55;
    addr = 1'b0; din = tx_byte; WE = 1'b1;
    tick();
    WE = 1'b0;
    for (int k = 0; k <= 160; k++) begin
      if ((k % 16 == 8) && (k < 160)) begin
        if (k / 16 == 0) exp_bit = 8'h00;
        else if (k / 16 == 9) exp_bit = 8'h01;
        else exp_bit = {7'b0, tx_byte[k/16 - 1]};
        chk($sformatf("tx55_bit%0d", k / 16), {7'b0, tx}, exp_bit);
      end
      if (k == 60 || k == 159) begin
        status_is($sformatf("tx_busy_k%0d", k), 8'h02);
        addr = 1'b0;
      end
      if (k == 160) begin
        status_is("tx_idle_k160", 8'h00);
        addr = 1'b0;
      end
      WE  = (k == 50);
      din = (k == 50) ? 8'hFF : tx_byte;
      tick();
    end
    WE = 1'b0;
    chk("tx_after_frame", {7'b0, tx}, 8'h01);

    // RX 0xA3
    send_rx(8'hA3, 1'b1);
    chk("rx_irq", {7'b0, irq}, 8'h01);
    status_is("rx_status", 8'h01);
    read_data("rx_data", 8'hA3);
    status_is("rx_status_after", 8'h00);
    chk("rx_irq_after", {7'b0, irq}, 8'h00);

    // Overrun: five frames into a four-deep FIFO
    for (int f = 1; f <= 5; f++) send_rx(8'(f), 1'b1);
    status_is("ovr_status", 8'h05);
    for (int f = 1; f <= 4; f++) read_data($sformatf("ovr_data%0d", f), 8'(f));
    addr = 1'b0; #1;
    chk("ovr_empty", dout, 8'h00);
    status_is("ovr_status_pre_clr", 8'h04);
    read_status_clear();
    status_is("ovr_status_clr", 8'h00);

    // Framing error, then a short glitch
    send_rx(8'h3C, 1'b0);
    status_is("ferr_status", 8'h08);
    chk("ferr_irq", {7'b0, irq}, 8'h00);
    read_status_clear();
    status_is("ferr_clr", 8'h00);
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (40) tick();
    status_is("glitch_status", 8'h00);
    chk("glitch_irq", {7'b0, irq}, 8'h00);

    // Reset during TX bit 4 while RX is mid-frame
    addr = 1'b0; din = 8'h0F; WE = 1'b1;
    fork
      send_rx(8'hF0, 1'b1);
    join_none
    tick();
    WE = 1'b0;
    repeat (88) tick();
    chk("mid_tx_bit4", {7'b0, tx}, 8'h00);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_tx", {7'b0, tx}, 8'h01);
    status_is("mid_rst_status", 8'h00);
    repeat (250) tick();
    status_is("mid_rst_later", 8'h00);
    chk("mid_rst_irq", {7'b0, irq}, 8'h00);

    // Full FIFO: pop coincides with the push of 0x99
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    send_rx(8'h33, 1'b1);
    send_rx(8'h44, 1'b1);
    status_is("full_status", 8'h01);
    fork
      send_rx(8'h99, 1'b1);
    join_none
    repeat (154) tick();
    addr = 1'b0; #1;
    chk("coll_head", dout, 8'h11);
    RE = 1'b1;
    tick();
    RE = 1'b0;
    status_is("coll_status", 8'h01);
    repeat (10) tick();
    for (int i = 0; i < 4; i++) read_data($sformatf("coll_data%0d", i), coll[i]);
    addr = 1'b0; #1;
    chk("coll_empty", dout, 8'h00);
    status_is("coll_final", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
